// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG arbiter.
//   trng_state_e : sequencer states (HOLD, WARMUP, RUN, FAIL)
//   DEF_*        : default top-level parameter values
//   FRESH_CYCLES : cycles a TRNG byte must age before it may be delivered
//   HOLD_CYCLES  : cycles the TRNG is held in reset before warm-up
package trng_pkg;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_WARMUP = 2'd1,
    ST_RUN    = 2'd2,
    ST_FAIL   = 2'd3
  } trng_state_e;

  localparam int unsigned DEF_NUM_REQ       = 4;
  localparam int unsigned DEF_WARMUP_CYCLES = 64;
  localparam int unsigned DEF_REP_LIMIT     = 4;
  localparam int unsigned FRESH_CYCLES      = 8;
  localparam int unsigned HOLD_CYCLES       = 2;

  // Bits needed to hold values 0..max_val, never less than one.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val > 1) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
//   req     : request vector
//   ptr     : highest-priority index this round
//   grant_c : one-hot winner (all zero when req is zero)
//   idx_c   : binary index of the winner
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         grant_c,
  output logic [$clog2(NUM_REQ)-1:0] idx_c
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  logic [PTR_W:0] cand;
  logic           found;

  // Scan from ptr upward, wrapping mod NUM_REQ; first set bit wins.
  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    found   = 1'b0;
    cand    = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = {1'b0, ptr} + (PTR_W+1)'(off);
      if (cand >= (PTR_W+1)'(NUM_REQ)) cand = cand - (PTR_W+1)'(NUM_REQ);
      if (!found && req[cand[PTR_W-1:0]]) begin
        found                      = 1'b1;
        grant_c[cand[PTR_W-1:0]]   = 1'b1;
        idx_c                      = cand[PTR_W-1:0];
      end
    end
  end

endmodule

// File: rtl/trng_arbiter.sv
// Shares one TRNG byte stream among NUM_REQ requesters with reset/warm-up
// sequencing, a freshness gap between deliveries and a repetition health test.
//   clk, n_reset : clock, async active-low reset
//   rand_in      : byte from the TRNG
//   trng_n_reset : registered active-low reset driven to the TRNG
//   req          : level requests, held until granted
//   gnt          : one-cycle one-hot grant
//   rand_data    : delivered byte, meaningful while valid=1
//   valid        : high exactly when gnt is non-zero
//   health_fail  : sticky repetition-test failure
//   clear_fail   : pulse that restarts the source from FAIL
module trng_arbiter
  import trng_pkg::*;
#(
  parameter int unsigned NUM_REQ       = DEF_NUM_REQ,
  parameter int unsigned WARMUP_CYCLES = DEF_WARMUP_CYCLES,
  parameter int unsigned REP_LIMIT     = DEF_REP_LIMIT
) (
  input  logic               clk,
  input  logic               n_reset,
  input  logic [7:0]         rand_in,
  output logic               trng_n_reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [7:0]         rand_data,
  output logic               valid,
  output logic               health_fail,
  input  logic               clear_fail
);

  localparam int unsigned PTR_W   = $clog2(NUM_REQ);
  localparam int unsigned HOLD_W  = cnt_width(HOLD_CYCLES - 1);
  localparam int unsigned WARM_W  = cnt_width(WARMUP_CYCLES - 1);
  localparam int unsigned FRESH_W = cnt_width(FRESH_CYCLES);
  localparam int unsigned REP_W   = cnt_width(REP_LIMIT);

  trng_state_e        state;
  logic [HOLD_W-1:0]  hold_cnt;
  logic [WARM_W-1:0]  warm_cnt;
  logic [FRESH_W-1:0] fresh_cnt;
  logic [REP_W-1:0]   rep_cnt;
  logic [PTR_W-1:0]   ptr;

  logic [NUM_REQ-1:0] win_c;
  logic [PTR_W-1:0]   win_idx_c;
  logic [PTR_W-1:0]   ptr_next_c;
  logic [REP_W-1:0]   rep_next_c;
  logic               try_grant_c;
  logic               rep_trip_c;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (req),
    .ptr     (ptr),
    .grant_c (win_c),
    .idx_c   (win_idx_c)
  );

  assign try_grant_c = (state == ST_RUN) && (fresh_cnt == FRESH_W'(FRESH_CYCLES)) && (|req);
  assign ptr_next_c  = (win_idx_c == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx_c + PTR_W'(1);

  // Repetition count the candidate byte would produce; rep_cnt=0 means no
  // byte delivered since RUN entry, and rand_data holds the last delivery.
  always_comb begin
    rep_next_c = REP_W'(1);
    if ((rep_cnt != '0) && (rand_in == rand_data)) rep_next_c = rep_cnt + REP_W'(1);
  end
  assign rep_trip_c = (rep_next_c == REP_W'(REP_LIMIT));

  // Sequencer, grant issue and health test.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state        <= ST_HOLD;
      trng_n_reset <= 1'b0;
      gnt          <= '0;
      valid        <= 1'b0;
      rand_data    <= 8'h00;
      health_fail  <= 1'b0;
      ptr          <= '0;
      hold_cnt     <= '0;
      warm_cnt     <= '0;
      fresh_cnt    <= '0;
      rep_cnt      <= '0;
    end else begin
      gnt   <= '0;
      valid <= 1'b0;
      case (state)
        ST_HOLD: begin
          trng_n_reset <= 1'b0;
          if (hold_cnt == HOLD_W'(HOLD_CYCLES - 1)) begin
            hold_cnt     <= '0;
            warm_cnt     <= '0;
            trng_n_reset <= 1'b1;
            state        <= ST_WARMUP;
          end else begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
        end

        ST_WARMUP: begin
          if (warm_cnt == WARM_W'(WARMUP_CYCLES - 1)) begin
            fresh_cnt <= '0;
            rep_cnt   <= '0;
            state     <= ST_RUN;
          end else begin
            warm_cnt <= warm_cnt + WARM_W'(1);
          end
        end

        ST_RUN: begin
          if (try_grant_c) begin
            if (rep_trip_c) begin
              health_fail  <= 1'b1;
              trng_n_reset <= 1'b0;
              state        <= ST_FAIL;
            end else begin
              gnt       <= win_c;
              valid     <= 1'b1;
              rand_data <= rand_in;
              rep_cnt   <= rep_next_c;
              ptr       <= ptr_next_c;
              // Counter clears on the sampling edge and the grant cycle is
              // the first aging cycle, so grants land exactly 8 cycles apart.
              fresh_cnt <= FRESH_W'(1);
            end
          end else if (fresh_cnt != FRESH_W'(FRESH_CYCLES)) begin
            fresh_cnt <= fresh_cnt + FRESH_W'(1);
          end
        end

        ST_FAIL: begin
          trng_n_reset <= 1'b0;
          if (clear_fail) begin
            health_fail <= 1'b0;
            hold_cnt    <= '0;
            state       <= ST_HOLD;
          end
        end

        default: state <= ST_HOLD;
      endcase
    end
  end

endmodule
